mult_div_unit: RTL and testbench

- Iterative multi-cycle multiply/divide unit for the MIPS datapath. Implements MULT, MULTU, DIV and DIVU.
- Operands come straight from the register file read ports (rs/rt data). Results go to architectural HI/LO registers.
- HI/LO are read back through MFHI/MFLO via the writeback mux into the register file write port.
- Uses shift-add multiply and restoring divide, one bit per cycle, with a busy/done handshake that the control unit uses to stall.

---
 rtl/mdu_pkg.sv | 37 +++
 rtl/mult_div_unit_if.sv | 30 +++
 rtl/mult_div_unit.sv | 164 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
// Holds the operation encoding, the FSM state encoding, the default datapath
// width, and the magnitude/negation helpers used on operands and results.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    // op[1] selects divide, op[0] selects unsigned.
    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

    function automatic logic [MDU_WIDTH-1:0] mdu_neg(input logic [MDU_WIDTH-1:0] x);
        return ~x + MDU_WIDTH'(1);
    endfunction

    function automatic logic [2*MDU_WIDTH-1:0] mdu_neg2(input logic [2*MDU_WIDTH-1:0] x);
        return ~x + (2*MDU_WIDTH)'(1);
    endfunction

    // Magnitude as an unsigned value; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude, so no extra bit is needed.
    function automatic logic [MDU_WIDTH-1:0] mdu_abs(input logic [MDU_WIDTH-1:0] x,
                                                     input logic is_signed);
        return (is_signed && x[MDU_WIDTH-1]) ? mdu_neg(x) : x;
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the control unit (master) and the MDU (slave).
// Master drives start/op/operands and mthi/mtlo writes; slave returns busy,
// the one-cycle done pulse and the architectural HI/LO registers.
interface mult_div_unit_if
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
);
    logic             start;
    mdu_op_e          op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_data, rt_data, mthi, mtlo, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, mthi, mtlo, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU: shift-add multiply, restoring divide, 1 bit/cycle.
// Latency: start in cycle 0, busy cycles 1..WIDTH+1, HI/LO + done pulse in cycle WIDTH+2.
// Backpressure: none queued; start/mthi/mtlo while busy are dropped, control stalls on busy.
// Ports: clk, reset (sync, active-high), mdu (slave modport: start/op/rs_data/rt_data,
//        mthi/mtlo/wdata in; busy/done/hi/lo out).
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
)(
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave mdu
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_e         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;   // product / quotient negate
    logic               neg_rem_q, neg_rem_d;   // remainder follows dividend sign
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   opb_q, opb_d;           // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc_q, acc_d;           // {hi_part, lo_part} working register
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH:0]     m_addend, m_sum;
    logic [WIDTH:0]     d_shift, d_trial;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;
    logic               start_signed, start_div;

    // One iteration of either algorithm.
    // Multiply: lower half holds the remaining multiplier bits; the sum is
    // shifted right together with it so the product fills the register.
    // Divide: lower half holds the dividend, shifted left into the remainder;
    // quotient bits enter from the right as dividend bits leave.
    always_comb begin
        m_addend = acc_q[0] ? {1'b0, opb_q} : '0;
        m_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + m_addend;
        d_shift  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        d_trial  = d_shift - {1'b0, opb_q};
        if (!is_div_q) begin
            acc_step = {m_sum, acc_q[WIDTH-1:1]};
        end else if (d_trial[WIDTH]) begin
            acc_step = {d_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            acc_step = {d_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
    end

    // Sign correction. Divide by zero leaves the magnitude dividend in the
    // remainder, so re-applying the dividend sign restores raw rs_data; only
    // the quotient needs forcing to all ones.
    always_comb begin
        prod_fix = neg_res_q ? mdu_neg2(acc_q) : acc_q;
        rem_fix  = neg_rem_q ? mdu_neg(acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
        if (div0_q) begin
            quot_fix = '1;
        end else begin
            quot_fix = neg_res_q ? mdu_neg(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
        end
    end

    assign start_signed = ~mdu.op[0];
    assign start_div    = mdu.op[1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        opb_d     = opb_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mdu.start) begin
                    is_div_d  = start_div;
                    neg_res_d = start_signed & (mdu.rs_data[WIDTH-1] ^ mdu.rt_data[WIDTH-1]);
                    neg_rem_d = start_signed & start_div & mdu.rs_data[WIDTH-1];
                    div0_d    = start_div & (mdu.rt_data == '0);
                    if (start_div) begin
                        opb_d = mdu_abs(mdu.rt_data, start_signed);
                        acc_d = {{WIDTH{1'b0}}, mdu_abs(mdu.rs_data, start_signed)};
                    end else begin
                        opb_d = mdu_abs(mdu.rs_data, start_signed);
                        acc_d = {{WIDTH{1'b0}}, mdu_abs(mdu.rt_data, start_signed)};
                    end
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CALC;
                end else begin
                    if (mdu.mthi) hi_d = mdu.wdata;
                    if (mdu.mtlo) lo_d = mdu.wdata;
                end
            end
            CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
            end
            FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            opb_q     <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            opb_q     <= opb_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign mdu.busy = busy_q;
    assign mdu.done = done_q;
    assign mdu.hi   = hi_q;
    assign mdu.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed, table-driven bench for mult_div_unit: vector table of operations
// with hand-computed HI/LO, plus sequences for ignored requests, mthi/mtlo and abort.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   applied = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(32)) mdu ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (mdu)
    );

    typedef struct {
        mdu_op_e     op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Called at a negedge; drives start for cycle 0 and checks cycles 1..34.
    // With inject set, a start and an mtlo are thrown at the unit mid-operation.
    task automatic run_op(input string nm, input mdu_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi,
                          input logic [31:0] elo, input bit inject);
        int bad = 0;
        logic [31:0] hi0, lo0;
        hi0 = mdu.hi;
        lo0 = mdu.lo;
        mdu.start   = 1'b1;
        mdu.op      = op;
        mdu.rs_data = a;
        mdu.rt_data = b;
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            if (c == 1) mdu.start = 1'b0;
            if (inject) begin
                if (c == 10) begin
                    mdu.start = 1'b1; mdu.op = MDU_DIVU;
                    mdu.rs_data = 32'd9; mdu.rt_data = 32'd3;
                end
                if (c == 11) mdu.start = 1'b0;
                if (c == 12) begin mdu.mtlo = 1'b1; mdu.wdata = 32'hDEADBEEF; end
                if (c == 13) mdu.mtlo = 1'b0;
            end
            if (mdu.busy !== (c <= 33)) bad++;
            if (mdu.done !== (c == 34)) bad++;
            if (c <= 33 && (mdu.hi !== hi0 || mdu.lo !== lo0)) bad++;
        end
        chk({nm, "_timing"}, 32'(bad), 32'd0);
        chk({nm, "_hi"}, mdu.hi, ehi);
        chk({nm, "_lo"}, mdu.lo, elo);
    endtask

    initial begin
        int nodone;
        vecs[0]  = '{MDU_MULT,  32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[4]  = '{MDU_DIVU,  32'd100,      32'h00000000, 32'h00000064, 32'hFFFFFFFF};
        vecs[5]  = '{MDU_DIV,   32'hFFFFFF9C, 32'h00000000, 32'hFFFFFF9C, 32'hFFFFFFFF};
        vecs[6]  = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[7]  = '{MDU_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
        vecs[8]  = '{MDU_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[9]  = '{MDU_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
        vecs[10] = '{MDU_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[11] = '{MDU_DIV,   32'h80000000, 32'h00000002, 32'h00000000, 32'hC0000000};

        reset = 1'b1;
        mdu.start = 1'b0; mdu.op = MDU_MULT; mdu.rs_data = '0; mdu.rt_data = '0;
        mdu.mthi = 1'b0; mdu.mtlo = 1'b0; mdu.wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_hi",   mdu.hi, 32'h0);
        chk("reset_lo",   mdu.lo, 32'h0);
        chk("reset_busy", 32'(mdu.busy), 32'd0);
        chk("reset_done", 32'(mdu.done), 32'd0);

        // Back-to-back: each op starts in the completing cycle of the previous one.
        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
                   vecs[i].exp_hi, vecs[i].exp_lo, 1'b0);
        end

        // Mid-operation start and mtlo are dropped; next start in cycle 34 is taken.
        run_op("ignore_midop", MDU_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b1);
        run_op("after_ignore", MDU_DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0);

        // mthi alone, then mthi+mtlo together.
        @(negedge clk);
        mdu.mthi = 1'b1; mdu.wdata = 32'h12345678;
        @(negedge clk);
        mdu.mthi = 1'b0;
        chk("mthi_hi", mdu.hi, 32'h12345678);
        chk("mthi_lo_kept", mdu.lo, 32'd3);
        mdu.mthi = 1'b1; mdu.mtlo = 1'b1; mdu.wdata = 32'hAAAA5555;
        @(negedge clk);
        mdu.mthi = 1'b0; mdu.mtlo = 1'b0;
        chk("mthilo_hi", mdu.hi, 32'hAAAA5555);
        chk("mthilo_lo", mdu.lo, 32'hAAAA5555);

        // start with mthi in the same cycle: start wins. Then abort by reset at cycle 20.
        mdu.start = 1'b1; mdu.op = MDU_MULT; mdu.rs_data = 32'd2; mdu.rt_data = 32'd3;
        mdu.mthi = 1'b1; mdu.wdata = 32'h11111111;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            if (c == 1) begin
                mdu.start = 1'b0; mdu.mthi = 1'b0;
                chk("start_beats_mthi", mdu.hi, 32'hAAAA5555);
                chk("busy_after_start", 32'(mdu.busy), 32'd1);
            end
            if (c == 20) reset = 1'b1;
            if (c == 21) reset = 1'b0;
        end
        chk("abort_hi",   mdu.hi, 32'h0);
        chk("abort_lo",   mdu.lo, 32'h0);
        chk("abort_busy", 32'(mdu.busy), 32'd0);
        nodone = 0;
        for (int c = 0; c < 40; c++) begin
            if (mdu.done !== 1'b0 || mdu.busy !== 1'b0) nodone++;
            @(negedge clk);
        end
        chk("abort_no_done", 32'(nodone), 32'd0);

        run_op("post_abort", MDU_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
